seq_divider8: RTL and testbench

SEQ_DIVIDER8 -- requirements
Module: seq_divider8

---
 rtl/seq_divider8.sv | 165 ++++++++++++++++
 tb/tb_seq_divider8.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider8.sv
// seq_divider8 -- 8-bit unsigned restoring divider, one quotient bit per clock.
// Start is level-sensitive (Run); a held Run produces exactly one division.
// Build option: define DIVZERO_CHECK_EN to short-cut a zero divisor straight
// to DONE with DivZero raised; otherwise a zero divisor runs the normal 8 steps
// and DivZero is tied low.
module seq_divider8 (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic [7:0] Dividend,
   input  logic [7:0] Divisor,
   output logic [7:0] Quotient,
   output logic [7:0] Remainder,
   output logic       Busy,
   output logic       Done,
   output logic       DivZero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state_r, state_s;
   logic [8:0]   a_r, a_s;        // partial remainder
   logic [7:0]   q_r, q_s;        // quotient shift register (dividend shifts out)
   logic [7:0]   m_r, m_s;        // divisor
   logic [2:0]   cnt_r, cnt_s;    // step counter
   logic [7:0]   quot_r, quot_s;
   logic [7:0]   rem_r, rem_s;
   logic         busy_r, done_r;
   logic [16:0]  step_s;          // {A_next, Q_next} of one restoring step

   // One restoring step: shift {A,Q} left, trial-subtract M, keep or restore.
   // The trial is done one bit wider so every bit of A takes part; because A
   // always stays below M, the sign bit matches a 9-bit trial subtraction.
   function automatic logic [16:0] div_step(input logic [8:0] a,
                                            input logic [7:0] q,
                                            input logic [7:0] m);
      logic [9:0] a_sh;
      logic [9:0] t;
      logic [7:0] q_sh;
      a_sh = {a, q[7]};
      q_sh = {q[6:0], 1'b0};
      t    = a_sh - {2'b00, m};
      if (t[9] == 1'b0) begin
         div_step = {t[8:0], q_sh | 8'h01};
      end else begin
         div_step = {a_sh[8:0], q_sh};
      end
   endfunction

`ifdef DIVZERO_CHECK_EN
   logic dz_r, dz_s;
`endif

   // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
   always_comb begin
      state_s = state_r;
      a_s     = a_r;
      q_s     = q_r;
      m_s     = m_r;
      cnt_s   = cnt_r;
      quot_s  = quot_r;
      rem_s   = rem_r;
`ifdef DIVZERO_CHECK_EN
      dz_s    = dz_r;
`endif
      step_s  = div_step(a_r, q_r, m_r);
      case (state_r)
         IDLE: begin
            if (Run) begin
               a_s     = 9'd0;
               q_s     = Dividend;
               m_s     = Divisor;
               cnt_s   = 3'd0;
               state_s = CALC;
`ifdef DIVZERO_CHECK_EN
               if (Divisor == 8'd0) begin
                  state_s = DONE;
                  quot_s  = 8'hFF;
                  rem_s   = Dividend;
                  dz_s    = 1'b1;
               end else begin
                  dz_s    = 1'b0;
               end
`endif
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            a_s   = step_s[16:8];
            q_s   = step_s[7:0];
            cnt_s = cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
               state_s = DONE;
               quot_s  = step_s[7:0];
               rem_s   = step_s[15:8];
            end else begin
               state_s = CALC;
            end
         end
         DONE: begin
            if (!Run) begin
               state_s = IDLE;
`ifdef DIVZERO_CHECK_EN
               dz_s    = 1'b0;
`endif
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= IDLE;
         a_r     <= 9'd0;
         q_r     <= 8'd0;
         m_r     <= 8'd0;
         cnt_r   <= 3'd0;
         quot_r  <= 8'd0;
         rem_r   <= 8'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         a_r     <= a_s;
         q_r     <= q_s;
         m_r     <= m_s;
         cnt_r   <= cnt_s;
         quot_r  <= quot_s;
         rem_r   <= rem_s;
         busy_r  <= (state_s == CALC);
         done_r  <= (state_s == DONE);
      end
   end

`ifdef DIVZERO_CHECK_EN
   // Divide-by-zero flag, raised with DONE and dropped on leaving it.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         dz_r <= 1'b0;
      end else begin
         dz_r <= dz_s;
      end
   end
   assign DivZero = dz_r;
`else
   assign DivZero = 1'b0;
`endif

   assign Quotient  = quot_r;
   assign Remainder = rem_r;
   assign Busy      = busy_r;
   assign Done      = done_r;

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: scoreboard of expected results pushed
// at each start and popped when Done rises. Honours DIVZERO_CHECK_EN.
module tb_seq_divider8;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Run;
   logic [7:0] Dividend;
   logic [7:0] Divisor;
   logic [7:0] Quotient;
   logic [7:0] Remainder;
   logic       Busy;
   logic       Done;
   logic       DivZero;

`ifdef DIVZERO_CHECK_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         lat;
   } exp_t;

   exp_t       sb[$];
   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [7:0] held_q = 8'd0;
   logic [7:0] held_r = 8'd0;

   seq_divider8 dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Run       (Run),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .Busy      (Busy),
      .Done      (Done),
      .DivZero   (DivZero)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] dd, input logic [7:0] dv);
      exp_t e;
      if (dv == 8'd0) begin
         e.q   = 8'hFF;
         e.r   = dd;
         e.dz  = DZ_EN;
         e.lat = DZ_EN ? 0 : 8;
      end else begin
         e.q   = dd / dv;
         e.r   = dd % dv;
         e.dz  = 1'b0;
         e.lat = 8;
      end
      sb.push_back(e);
   endtask

   // Entered just after the start edge; counts edges until Done, then checks.
   task automatic wait_result(input int hold);
      int   lat = 0;
      exp_t e;
      @(negedge Clk);
      if (hold == 0) Run = 1'b0;
      Dividend = 8'($urandom);
      Divisor  = 8'($urandom);
      while (!Done && lat < 20) begin
         check("busy_calc", Busy, 1);
         check("q_hold_calc", Quotient, held_q);
         check("r_hold_calc", Remainder, held_r);
         @(posedge Clk);
         lat++;
         @(negedge Clk);
      end
      check("sb_size", sb.size(), 1);
      e = sb.pop_front();
      check("done_seen", Done, 1);
      check("latency", lat, e.lat);
      check("quotient", Quotient, e.q);
      check("remainder", Remainder, e.r);
      check("divzero", DivZero, e.dz);
      check("busy_at_done", Busy, 0);
      held_q = e.q;
      held_r = e.r;
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge Clk);
            check("done_hold", Done, 1);
            check("busy_hold", Busy, 0);
            check("q_hold_done", Quotient, held_q);
         end
         Run = 1'b0;
      end
      @(negedge Clk);
      check("idle_done", Done, 0);
      check("idle_busy", Busy, 0);
      check("idle_dz", DivZero, 0);
      check("q_hold_idle", Quotient, held_q);
      check("r_hold_idle", Remainder, held_r);
   endtask

   task automatic do_div(input logic [7:0] dd, input logic [7:0] dv, input int hold);
      @(negedge Clk);
      Run      = 1'b1;
      Dividend = dd;
      Divisor  = dv;
      push_exp(dd, dv);
      @(posedge Clk);
      wait_result(hold);
      if (dv != 8'd0) begin
         check("identity", int'(Quotient) * int'(dv) + int'(Remainder), int'(dd));
         check("rem_lt_div", Remainder < dv, 1);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset    = 1'b1;
      Run      = 1'b0;
      Dividend = 8'd0;
      Divisor  = 8'd0;
      repeat (2) @(negedge Clk);
      check("rst_quotient", Quotient, 0);
      check("rst_remainder", Remainder, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_divzero", DivZero, 0);
      Reset = 1'b0;

      do_div(8'd100, 8'd7, 0);
      do_div(8'd255, 8'd1, 0);
      do_div(8'd5, 8'd9, 0);
      do_div(8'd200, 8'd16, 21);
      do_div(8'd77, 8'd0, 0);

      // Abort 100/7 with Reset sampled on the 4th CALC edge.
      @(negedge Clk);
      Run      = 1'b1;
      Dividend = 8'd100;
      Divisor  = 8'd7;
      @(posedge Clk);
      @(negedge Clk);
      Run = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      check("abort_busy", Busy, 0);
      check("abort_done", Done, 0);
      check("abort_quotient", Quotient, 0);
      check("abort_remainder", Remainder, 0);
      check("abort_divzero", DivZero, 0);
      Reset  = 1'b0;
      held_q = 8'd0;
      held_r = 8'd0;
      repeat (12) @(negedge Clk);
      check("abort_no_done", Done, 0);
      check("abort_q_kept", Quotient, 0);
      do_div(8'd50, 8'd6, 0);

      // Reset held with Run high must not start; release starts at once.
      @(negedge Clk);
      Reset    = 1'b1;
      Run      = 1'b1;
      Dividend = 8'd200;
      Divisor  = 8'd3;
      repeat (3) begin
         @(negedge Clk);
         check("rst_run_busy", Busy, 0);
         check("rst_run_done", Done, 0);
      end
      held_q = 8'd0;
      held_r = 8'd0;
      push_exp(8'd200, 8'd3);
      Reset = 1'b0;
      @(posedge Clk);
      wait_result(0);

      for (int i = 0; i < 1000; i++) begin
         do_div(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
